// File: rtl/axi_fault_monitor.sv
// axi_fault_monitor: passive AXI fault monitor.
// It snoops the AW/B/AR/R handshakes and tracks outstanding transactions in one
// in-order tracker per direction. It flags error responses, unexpected responses,
// response timeouts and tracker overflow. The first fault is held in sticky
// capture registers, and a saturating counter counts the cycles that carry faults.
module axi_fault_monitor #(
    parameter int ADDR_W   = 32,
    parameter int ID_W     = 4,
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 8,
    parameter bit FATAL_EN = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              awvalid,
    input  logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [ID_W-1:0]   awid,
    input  logic              bvalid,
    input  logic              bready,
    input  logic [1:0]        bresp,
    input  logic [ID_W-1:0]   bid,
    input  logic              arvalid,
    input  logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [ID_W-1:0]   arid,
    input  logic              rvalid,
    input  logic              rready,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    input  logic [ID_W-1:0]   rid,
    input  logic              i_clr,
    output logic              access_fault,
    output logic [2:0]        fault_code,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [ID_W-1:0]   fault_id,
    output logic [CNT_W-1:0]  fault_cnt,
    output logic              fault_pulse
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TRK_W = PTR_W + 1;
    localparam int AGE_W = $clog2(TIMEOUT + 1);

    localparam logic [TRK_W-1:0] TRK_FULL  = TRK_W'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX   = AGE_W'(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_FIRE  = AGE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // Handshake qualifiers
    logic aw_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = awvalid & awready;
    assign b_hs  = bvalid & bready;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;

    // Per-direction tracker interface: index 0 = write, index 1 = read
    logic [1:0]        req_push;
    logic [1:0]        req_pop;
    logic [1:0]        trk_empty;
    logic [1:0]        trk_ovf;
    logic [1:0]        trk_fire;
    logic [ADDR_W-1:0] push_addr [2];
    logic [ID_W-1:0]   push_id   [2];
    logic [ADDR_W-1:0] head_addr [2];
    logic [ID_W-1:0]   head_id   [2];

    assign req_push[0]  = aw_hs;
    assign req_pop[0]   = b_hs;
    assign push_addr[0] = awaddr;
    assign push_id[0]   = awid;
    assign req_push[1]  = ar_hs;
    assign req_pop[1]   = r_hs & rlast;
    assign push_addr[1] = araddr;
    assign push_id[1]   = arid;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_trk
            logic [ADDR_W-1:0] addr_mem [DEPTH];
            logic [ID_W-1:0]   id_mem   [DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [TRK_W-1:0]  count_reg;
            logic [AGE_W-1:0]  age_reg;
            logic              empty, full, pop, push;

            assign empty = (count_reg == '0);
            assign full  = (count_reg == TRK_FULL);
            // A pop on an empty tracker is dropped; mismatched responses still pop to stay in sync
            assign pop   = req_pop[gi] & ~empty;
            // When the tracker is full, a same-cycle pop frees the slot for the push
            assign push  = req_push[gi] & (~full | pop);

            assign trk_empty[gi] = empty;
            assign trk_ovf[gi]   = req_push[gi] & full & ~pop;
            // Fires on the cycle the age counter steps onto TIMEOUT; holding there prevents a refire
            assign trk_fire[gi]  = ~empty & ~pop & (age_reg == AGE_FIRE);
            assign head_addr[gi] = addr_mem[rd_ptr_reg];
            assign head_id[gi]   = id_mem[rd_ptr_reg];

            // Tracker storage write (no reset needed: occupancy is tracked by count_reg)
            always_ff @(posedge i_clk) begin
                if (push) begin
                    addr_mem[wr_ptr_reg] <= push_addr[gi];
                    id_mem[wr_ptr_reg]   <= push_id[gi];
                end
            end

            // Pointers, occupancy and head-entry age
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    age_reg    <= '0;
                end else begin
                    if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    if (push && !pop)      count_reg <= count_reg + TRK_W'(1);
                    else if (pop && !push) count_reg <= count_reg - TRK_W'(1);
                    if (pop || empty)           age_reg <= '0;
                    else if (age_reg != AGE_MAX) age_reg <= age_reg + AGE_W'(1);
                end
            end
        end
    endgenerate

    // Fault flags indexed by fault code
    logic [7:1] flt;
    assign flt[1] = b_hs & bresp[1];
    assign flt[2] = r_hs & rresp[1];
    assign flt[3] = b_hs & (trk_empty[0] | (bid != head_id[0]));
    assign flt[4] = r_hs & (trk_empty[1] | (rid != head_id[1]));
    assign flt[5] = trk_fire[0];
    assign flt[6] = trk_fire[1];
    assign flt[7] = trk_ovf[0] | trk_ovf[1];

    logic any_fault;
    assign any_fault = |flt;

    logic [2:0]        code_next;
    logic [ADDR_W-1:0] addr_next;
    logic [ID_W-1:0]   id_next;

    // Lowest code wins when several faults land in the same cycle
    always_comb begin
        code_next = 3'd0;
        addr_next = '0;
        id_next   = '0;
        if (flt[1]) begin
            code_next = 3'd1; addr_next = head_addr[0]; id_next = head_id[0];
        end else if (flt[2]) begin
            code_next = 3'd2; addr_next = head_addr[1]; id_next = head_id[1];
        end else if (flt[3]) begin
            code_next = 3'd3; id_next = bid;
        end else if (flt[4]) begin
            code_next = 3'd4; id_next = rid;
        end else if (flt[5]) begin
            code_next = 3'd5; addr_next = head_addr[0]; id_next = head_id[0];
        end else if (flt[6]) begin
            code_next = 3'd6; addr_next = head_addr[1]; id_next = head_id[1];
        end else if (flt[7]) begin
            code_next = 3'd7;
            addr_next = trk_ovf[0] ? awaddr : araddr;
            id_next   = trk_ovf[0] ? awid   : arid;
        end
    end

    logic              access_fault_reg;
    logic [2:0]        fault_code_reg;
    logic [ADDR_W-1:0] fault_addr_reg;
    logic [ID_W-1:0]   fault_id_reg;
    logic [CNT_W-1:0]  fault_cnt_reg;
    logic              fault_pulse_reg;

    // Sticky first-fault capture, saturating counter and registered pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            access_fault_reg <= 1'b0;
            fault_code_reg   <= '0;
            fault_addr_reg   <= '0;
            fault_id_reg     <= '0;
            fault_cnt_reg    <= '0;
            fault_pulse_reg  <= 1'b0;
        end else begin
            fault_pulse_reg <= any_fault;
            if (i_clr) begin
                // A fault in the clear cycle becomes the new first fault
                access_fault_reg <= any_fault;
                fault_code_reg   <= code_next;
                fault_addr_reg   <= addr_next;
                fault_id_reg     <= id_next;
                fault_cnt_reg    <= any_fault ? CNT_W'(1) : '0;
            end else if (any_fault) begin
                if (!access_fault_reg) begin
                    access_fault_reg <= 1'b1;
                    fault_code_reg   <= code_next;
                    fault_addr_reg   <= addr_next;
                    fault_id_reg     <= id_next;
                end
                if (fault_cnt_reg != CNT_MAX) fault_cnt_reg <= fault_cnt_reg + CNT_W'(1);
            end
        end
    end

    generate
        if (FATAL_EN) begin : g_fatal
`ifndef SYNTHESIS
            // Stop simulation on the first captured fault
            always_ff @(posedge i_clk) begin
                if (i_rst_n && any_fault && (!access_fault_reg || i_clr))
                    $fatal(1, "axi_fault_monitor: code=%0d addr=0x%0h id=%0d",
                           code_next, addr_next, id_next);
            end
`endif
        end
    endgenerate

    assign access_fault = access_fault_reg;
    assign fault_code   = fault_code_reg;
    assign fault_addr   = fault_addr_reg;
    assign fault_id     = fault_id_reg;
    assign fault_cnt    = fault_cnt_reg;
    assign fault_pulse  = fault_pulse_reg;

endmodule

// File: tb/tb_axi_fault_monitor.sv
// Directed testbench for axi_fault_monitor (DEPTH=4, TIMEOUT=16, CNT_W=8).
module tb_axi_fault_monitor;

    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int CNT_W  = 8;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              awvalid = 0, awready = 0;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [ID_W-1:0]   awid = '0;
    logic              bvalid = 0, bready = 0;
    logic [1:0]        bresp = '0;
    logic [ID_W-1:0]   bid = '0;
    logic              arvalid = 0, arready = 0;
    logic [ADDR_W-1:0] araddr = '0;
    logic [ID_W-1:0]   arid = '0;
    logic              rvalid = 0, rready = 0, rlast = 0;
    logic [1:0]        rresp = '0;
    logic [ID_W-1:0]   rid = '0;
    logic              i_clr = 0;
    logic              access_fault;
    logic [2:0]        fault_code;
    logic [ADDR_W-1:0] fault_addr;
    logic [ID_W-1:0]   fault_id;
    logic [CNT_W-1:0]  fault_cnt;
    logic              fault_pulse;

    int checks = 0;
    int failures = 0;

    axi_fault_monitor #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(4), .TIMEOUT(16), .CNT_W(CNT_W), .FATAL_EN(1'b0)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp), .rid(rid),
        .i_clr(i_clr),
        .access_fault(access_fault), .fault_code(fault_code), .fault_addr(fault_addr),
        .fault_id(fault_id), .fault_cnt(fault_cnt), .fault_pulse(fault_pulse)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic idle();
        awvalid = 0; bvalid = 0; arvalid = 0; rvalid = 0; rlast = 0; i_clr = 0;
        bresp = 2'b00; rresp = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        i_rst_n = 0;
        steps(2);
        i_rst_n = 1;
        step();
    endtask

    task automatic capture(input string tag, input logic [2:0] code, input logic [31:0] addr,
                           input logic [3:0] id, input logic [7:0] cnt);
        chk({tag, ".af"},   access_fault, 1'b1);
        chk({tag, ".code"}, fault_code, code);
        chk({tag, ".addr"}, fault_addr, addr);
        chk({tag, ".id"},   fault_id, id);
        chk({tag, ".cnt"},  fault_cnt, cnt);
    endtask

    initial begin
        awready = 1; bready = 1; arready = 1; rready = 1;

        // Reset state
        do_reset();
        chk("rst.af", access_fault, 1'b0);
        chk("rst.code", fault_code, 3'd0);
        chk("rst.cnt", fault_cnt, 8'd0);
        chk("rst.pulse", fault_pulse, 1'b0);

        // WR_RESP: AW then SLVERR B
        awvalid = 1; awaddr = 32'h8000_0000; awid = 4'd2; step(); awvalid = 0;
        bvalid = 1; bresp = 2'b10; bid = 4'd2; step(); bvalid = 0; bresp = 2'b00;
        capture("wrresp", 3'd1, 32'h8000_0000, 4'd2, 8'd1);
        chk("wrresp.pulse", fault_pulse, 1'b1);
        step();
        chk("wrresp.pulse_gone", fault_pulse, 1'b0);
        // Entry was popped: another B is now unexpected (counter only)
        bvalid = 1; bid = 4'd2; step(); bvalid = 0;
        chk("wrresp.popped_cnt", fault_cnt, 8'd2);
        chk("wrresp.sticky_code", fault_code, 3'd1);
        // Plain clear
        i_clr = 1; step(); i_clr = 0;
        chk("clr.af", access_fault, 1'b0);
        chk("clr.cnt", fault_cnt, 8'd0);
        chk("clr.code", fault_code, 3'd0);

        // RD_RESP: 4-beat burst, beat 2 DECERR
        do_reset();
        arvalid = 1; araddr = 32'h0000_1000; arid = 4'd1; step(); arvalid = 0;
        rvalid = 1; rid = 4'd1;
        for (int b = 1; b <= 4; b++) begin
            rresp = (b == 2) ? 2'b11 : 2'b00;
            rlast = (b == 4);
            step();
            if (b == 2) chk("rdresp.pulse", fault_pulse, 1'b1);
        end
        rvalid = 0; rlast = 0; rresp = 2'b00;
        capture("rdresp", 3'd2, 32'h0000_1000, 4'd1, 8'd1);
        // Tracker is empty: one more R beat is unexpected
        rvalid = 1; rlast = 1; rid = 4'd1; step(); rvalid = 0; rlast = 0;
        chk("rdresp.empty_cnt", fault_cnt, 8'd2);

        // B_UNEXP on empty write tracker
        do_reset();
        bvalid = 1; bid = 4'd5; step(); bvalid = 0;
        capture("bunexp", 3'd3, 32'h0, 4'd5, 8'd1);
        // Tracker stayed empty: a matched AW/B pair raises nothing new
        awvalid = 1; awaddr = 32'h40; awid = 4'd5; step(); awvalid = 0;
        bvalid = 1; bid = 4'd5; step(); bvalid = 0;
        step();
        chk("bunexp.nofault_cnt", fault_cnt, 8'd1);
        chk("bunexp.nofault_pulse", fault_pulse, 1'b0);

        // WR_TIMEOUT
        do_reset();
        awvalid = 1; awaddr = 32'h2000; awid = 4'd3; step(); awvalid = 0;
        steps(15);
        chk("tmo.before", access_fault, 1'b0);
        step();
        capture("tmo", 3'd5, 32'h2000, 4'd3, 8'd1);
        chk("tmo.pulse", fault_pulse, 1'b1);
        steps(40);
        chk("tmo.norefire", fault_cnt, 8'd1);
        bvalid = 1; bid = 4'd3; step(); bvalid = 0;
        step();
        chk("tmo.late_b_pulse", fault_pulse, 1'b0);
        steps(20);
        chk("tmo.late_b_cnt", fault_cnt, 8'd1);

        // OVERFLOW on read tracker, then full pop+push
        do_reset();
        for (int i = 0; i < 5; i++) begin
            arvalid = 1; araddr = 32'(i * 32'h100); arid = 4'(i);
            step();
            if (i == 3) chk("ovf.full_no_fault", access_fault, 1'b0);
        end
        arvalid = 0;
        capture("ovf", 3'd7, 32'h400, 4'd4, 8'd1);
        arvalid = 1; araddr = 32'h900; arid = 4'd9;
        rvalid = 1; rlast = 1; rid = 4'd0;
        step();
        arvalid = 0;
        chk("ovf.poppush_pulse", fault_pulse, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            rid = 4'(i); step();
        end
        rid = 4'd9; step();
        rvalid = 0; rlast = 0;
        step();
        chk("ovf.drain_cnt", fault_cnt, 8'd1);

        // Clear with simultaneous R_UNEXP, saturation, async reset
        do_reset();
        bvalid = 1; bid = 4'd1; step(); bvalid = 0;
        chk("sat.first_code", fault_code, 3'd3);
        i_clr = 1; rvalid = 1; rlast = 1; rid = 4'd7; step();
        i_clr = 0; rvalid = 0; rlast = 0;
        capture("clrfault", 3'd4, 32'h0, 4'd7, 8'd1);
        bvalid = 1; bid = 4'd1;
        steps(300);
        chk("sat.cnt", fault_cnt, 8'd255);
        chk("sat.code", fault_code, 3'd4);
        steps(2);
        #2 i_rst_n = 0;
        #1;
        chk("arst.af", access_fault, 1'b0);
        chk("arst.code", fault_code, 3'd0);
        chk("arst.addr", fault_addr, 32'h0);
        chk("arst.id", fault_id, 4'd0);
        chk("arst.cnt", fault_cnt, 8'd0);
        chk("arst.pulse", fault_pulse, 1'b0);
        idle();
        steps(2);
        i_rst_n = 1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_fault_monitor.md
Name: axi_fault_monitor

Overview:
- Parametrised, synthesizable AXI bus fault monitor; successor to the simulation-only response checker.
- Passively snoops AW/B/AR/R handshakes and tracks outstanding transactions per direction in in-order trackers.
- Detects error responses, unexpected responses, tracker overflow and response timeouts.
- Captures the first fault (code/addr/id) in sticky registers and keeps a saturating fault counter; clearable by software.

Parameters:
ADDR_W, 32, address width
ID_W, 4, AXI ID width
DEPTH, 4, max outstanding transactions tracked per direction (power of 2, >=2)
TIMEOUT, 1024, cycles an outstanding head entry may wait for its response
CNT_W, 8, fault counter width
FATAL_EN, 0, 1 = $fatal on first fault in simulation (excluded under SYNTHESIS)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
awvalid/awready  in  1/1  AW handshake
awaddr/awid  in  ADDR_W/ID_W  AW payload
bvalid/bready  in  1/1  B handshake
bresp/bid  in  2/ID_W  B payload
arvalid/arready  in  1/1  AR handshake
araddr/arid  in  ADDR_W/ID_W  AR payload
rvalid/rready/rlast  in  1/1/1  R handshake, last beat
rresp/rid  in  2/ID_W  R payload
i_clr  in  1  synchronous clear of capture registers and counter
access_fault  out  1  sticky; high while a fault is captured
fault_code  out  3  code of first captured fault
fault_addr  out  ADDR_W  address of first captured fault
fault_id  out  ID_W  ID of first captured fault
fault_cnt  out  CNT_W  saturating count of fault cycles
fault_pulse  out  1  one-cycle pulse on any cycle with >=1 new fault

Behaviour:
- Reset (async, i_rst_n=0): both trackers empty, age counters 0; all outputs 0.
- Handshake = valid & ready, sampled at the rising edge of i_clk. The W channel is not checked.
- Write tracker: FIFO of {awaddr, awid}, DEPTH entries. Push on AW handshake; pop on B handshake.
- Read tracker: FIFO of {araddr, arid}. Push on AR handshake; pop on an R handshake with rlast=1.
- Pop and push in the same cycle are both legal when the tracker is full: the pop frees the slot for the push.
- Fault codes:
  - 1 WR_RESP: B handshake, bresp[1]=1 (SLVERR/DECERR). OKAY and EXOKAY are not faults.
  - 2 RD_RESP: any R handshake with rresp[1]=1. The tracker pops only on rlast.
  - 3 B_UNEXP: B handshake with the write tracker empty, or bid != head id.
  - 4 R_UNEXP: R handshake with the read tracker empty, or rid != head id.
  - 5 WR_TIMEOUT: write age counter reaches TIMEOUT.
  - 6 RD_TIMEOUT: read age counter reaches TIMEOUT.
  - 7 OVERFLOW: AW or AR handshake when that tracker is full with no same-cycle pop.
- Pop and drop rules for faulted transactions:
  - A B_UNEXP/R_UNEXP with a non-empty tracker still pops, to stay in sync.
  - With an empty tracker, no pop occurs.
  - An OVERFLOW push is dropped.
- Age counters (one per direction):
  - Cleared on pop or when the tracker is empty; otherwise increment each cycle.
  - Fire once at ==TIMEOUT, then hold until the next pop.
- Captured address/id per code:
  - 1/2/5/6: head entry addr/id.
  - 3/4: addr=0, id=bid/rid.
  - 7: awaddr/awid, or araddr/arid.
- Same-cycle multiple faults: the lowest code wins capture; fault_cnt increments by 1 only.
- Capture:
  - Only when access_fault=0; later faults update fault_cnt only.
  - Registers are visible the cycle after detection; fault_pulse is registered and aligned with them.
- fault_cnt saturates at all-ones.
- i_clr:
  - Next cycle: access_fault/code/addr/id/cnt = 0. Trackers are unaffected.
  - If a fault occurs in the i_clr cycle, the new fault is captured and fault_cnt=1.
- FATAL_EN=1: $fatal with code/addr/id when the first capture occurs (simulation only).

Test Plan:
- AW addr 0x8000_0000 id 2, then B bresp=2'b10 bid 2 -> next cycle access_fault=1, code=1, addr=0x8000_0000, id=2, cnt=1, one fault_pulse.
- AR id 1, 4-beat R, beat 2 rresp=2'b11, rlast on beat 4 -> code=2; tracker empty after beat 4; cnt=1 (beat 2 only).
- B handshake with no outstanding write, bid=5 -> code=3, addr=0, id=5; write tracker remains empty.
- TIMEOUT=16, AW with no B -> fault exactly 16 cycles after the push, code=5; no refire while B stays absent; B arriving later pops with no new fault.
- DEPTH=4, five AR with no R -> 5th gives code=7; same-cycle R-last pop plus AR on a full tracker -> no fault.
- Fault, then i_clr asserted while a simultaneous R_UNEXP occurs -> code=4, cnt=1; 300 further faults with CNT_W=8 -> cnt=255; asserting i_rst_n low mid-burst -> all outputs 0 immediately.
